shift_cmd_sequencer: RTL and testbench
======================================

Name: shift_cmd_sequencer

Overview:
- Upstream feeder for the 8-bit registered barrel shifter (inputs x, shamt, LR, AL; output y).
- Accepts shift commands over a valid/ready interface and buffers them in a small FIFO.
- Drives each command into the shifter and holds it stable until the shifter's two-edge pipeline has produced y.
- Captures y into a result register and presents it, with a sequence tag, over a valid/ready output interface.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the sequence tag; wraps modulo 2^TAG_W.

Ports:
- Clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge Clk.
- in_valid  input  1  command offered.
- in_ready  output  1  command FIFO can accept.
- in_x  input  8  operand.
- in_shamt  input  3  shift amount.
- in_lr  input  1  0 = right, 1 = left.
- in_al  input  1  0 = logical, 1 = arithmetic.
- sh_x  output  8  to shifter x.
- sh_shamt  output  3  to shifter shamt.
- sh_lr  output  1  to shifter LR.
- sh_al  output  1  to shifter AL.
- sh_y  input  8  from shifter y.
- res_valid  output  1  result register holds data.
- res_ready  input  1  consumer takes the result.
- res_y  output  8  captured shift result.
- res_tag  output  TAG_W  tag of the command that produced res_y.

Behaviour:
- Reset (rst_n=0 at an edge) sets the following; it overrides everything and aborts any in-flight command:
  - FIFO empty, in_ready=1.
  - sh_x, sh_shamt, sh_lr, sh_al = 0.
  - res_valid=0, res_y=0, res_tag=0.
  - Tag counter = 0, state = IDLE.
- Input handshake: push when in_valid && in_ready. in_ready = !full, registered-state only, with no bypass. A push when full cannot occur. The FIFO stores {x, shamt, lr, al, tag}. The tag counter increments on every push.
- State machine: IDLE, ISSUE1, ISSUE2, CAPTURE.
  - IDLE:
    - If the FIFO is not empty: pop the head into the sh_* registers at the edge, then go to ISSUE1.
    - Otherwise: sh_* hold their last values.
  - ISSUE1 -> ISSUE2 unconditionally. sh_* held. (The shifter latches the op on this edge.)
  - ISSUE2 -> CAPTURE unconditionally. sh_* held. (The shifter computes y on this edge.)
  - CAPTURE: sh_y is valid this cycle.
    - If the result slot is free (res_valid=0 or res_ready=1):
      - Load res_y <= sh_y, res_tag <= the in-flight tag, res_valid <= 1.
      - If the FIFO is not empty, pop the next command into sh_* and go to ISSUE1; else go to IDLE.
    - Otherwise stay in CAPTURE with sh_* held, so sh_y stays stable.
- Output handshake:
  - res_valid clears on res_ready, unless a new capture happens on the same edge, in which case it stays 1 with the new data.
  - res_y and res_tag are stable while res_valid=1 && res_ready=0.
- Push and pop may occur on the same edge at any occupancy below full. The occupancy count stays correct, and read/write pointers wrap modulo DEPTH.
- Latency: push at edge E0, then IDLE in cycle 1, sh_* driven from cycle 2, capture at the end of cycle 4, res_valid=1 in cycle 5.
- Throughput: one result per 3 cycles with res_ready held at 1.
- Results leave in push order. Tags are consecutive modulo 2^TAG_W.

Test Plan:
- Single command, x=0xB4, shamt=2, lr=0, al=1 (arithmetic right), res_ready=1 -> res_valid rises 5 cycles after push; res_y=0xED, res_tag=0.
- Logical left, x=0x81, shamt=3, lr=1, al=0 -> res_y=0x08. Logical right, x=0x81, shamt=7 -> res_y=0x01.
- Burst of 6 pushes with res_ready=0:
  - First result captured; second command stalls in CAPTURE with sh_* frozen.
  - FIFO fills to 4, in_ready=0, and remaining pushes wait.
  - Raising res_ready drains all 6 in order, tags 0..5.
- Backpressure: res_ready=0 for 10 cycles -> res_y/res_tag unchanged, sh_y stable, no command lost. On release, res_valid stays 1 back-to-back with the next result.
- Reset asserted while in ISSUE2 with 2 queued commands -> next cycle all outputs 0, in_ready=1, nothing emitted. A subsequent push produces tag 0.
- 17 commands streamed -> tags 0..15 then 0 (wrap). Pointer wrap exercised; all results match the shifter model.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO plus sequencer that feeds an 8-bit two-stage registered barrel shifter,
// holds each operation until its result emerges, and returns tagged results over valid/ready.
module shift_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [2:0]       in_shamt,
    input  logic             in_lr,
    input  logic             in_al,
    output logic [7:0]       sh_x,
    output logic [2:0]       sh_shamt,
    output logic             sh_lr,
    output logic             sh_al,
    input  logic [7:0]       sh_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_y,
    output logic [TAG_W-1:0] res_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE1  = 2'd1,
        ISSUE2  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]       x;
        logic [2:0]       shamt;
        logic             lr;
        logic             al;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    cmd_t             cmd_q, cmd_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_y_q, res_y_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic slot_free;
    cmd_t push_entry;

    assign in_ready   = (count_q != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);
    assign slot_free  = !res_valid_q || res_ready;
    assign push_entry = {in_x, in_shamt, in_lr, in_al, tag_cnt_q};

    // Storage array carries no reset so it can map onto distributed RAM.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tag_cnt_d = tag_cnt_q;
        if (push) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            tag_cnt_d = tag_cnt_q + TAG_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        pop         = 1'b0;
        res_valid_d = res_valid_q && !res_ready;
        res_y_d     = res_y_q;
        res_tag_d   = res_tag_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE1;
                end
            end
            ISSUE1: state_d = ISSUE2;
            ISSUE2: state_d = CAPTURE;
            CAPTURE: begin
                // Without a free slot the operands stay frozen so sh_y stays valid.
                if (slot_free) begin
                    res_valid_d = 1'b1;
                    res_y_d     = sh_y;
                    res_tag_d   = cmd_q.tag;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            cmd_d = fifo_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_cnt_q   <= '0;
            cmd_q       <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_cnt_q   <= tag_cnt_d;
            cmd_q       <= cmd_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign sh_x      = cmd_q.x;
    assign sh_shamt  = cmd_q.shamt;
    assign sh_lr     = cmd_q.lr;
    assign sh_al     = cmd_q.al;
    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer: a two-edge shifter model closes the loop,
// table vectors cover the shift function, hand sequences cover stalls, reset and wrap.
module tb_shift_cmd_sequencer;

    logic       Clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [2:0] in_shamt;
    logic       in_lr;
    logic       in_al;
    logic [7:0] sh_x;
    logic [2:0] sh_shamt;
    logic       sh_lr;
    logic       sh_al;
    logic [7:0] sh_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_y;
    logic [3:0] res_tag;

    shift_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_shamt  (in_shamt),
        .in_lr     (in_lr),
        .in_al     (in_al),
        .sh_x      (sh_x),
        .sh_shamt  (sh_shamt),
        .sh_lr     (sh_lr),
        .sh_al     (sh_al),
        .sh_y      (sh_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_tag   (res_tag)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] shf(input logic [7:0] x, input logic [2:0] s,
                                       input logic lr, input logic al);
        logic signed [7:0] sx;
        sx = x;
        if (lr) return x << s;
        if (al) return sx >>> s;
        return x >> s;
    endfunction

    // Shifter model: op latched on the first edge, y produced on the second.
    logic [7:0] op_x;
    logic [2:0] op_s;
    logic       op_lr, op_al;
    always @(posedge Clk) begin
        op_x  <= sh_x;
        op_s  <= sh_shamt;
        op_lr <= sh_lr;
        op_al <= sh_al;
        sh_y  <= shf(op_x, op_s, op_lr, op_al);
    end

    int          tests = 0;
    int          fails = 0;
    int          n_out = 0;
    logic [3:0]  tb_tag;
    logic [3:0]  last_tag;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    typedef struct {
        logic [7:0] x;
        logic [2:0] s;
        logic       lr;
        logic       al;
        logic [7:0] y;
    } vec_t;
    vec_t vecs[10];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] x, input logic [2:0] s, input logic lr, input logic al);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_x     = x;
        in_shamt = s;
        in_lr    = lr;
        in_al    = al;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 60) begin
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (ok) begin
            exp_q.push_back({tb_tag, shf(x, s, lr, al)});
            last_tag = tb_tag;
            tb_tag   = tb_tag + 4'd1;
        end else begin
            tests++;
            fails++;
            $display("FAIL push_timeout: in_ready got 0 for 60 cycles, required 1");
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        check(name, 32'(res_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        exp_q.delete();
        tb_tag = 4'd0;
        rst_n  = 1'b1;
    endtask

    // Output scoreboard: a transfer happens at the next edge when valid and ready are both high.
    always @(negedge Clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got y=%02h tag=%0d, required no result", res_y, res_tag);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] result y=%02h tag=%0d", res_y, res_tag);
                check("out_y", 32'(res_y), 32'(mon_e[7:0]));
                check("out_tag", 32'(res_tag), 32'(mon_e[11:8]));
                n_out++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, required finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] bx[7];
    logic [2:0] bs[7];
    logic       blr[7];
    logic       bal[7];
    int         n0;

    initial begin
        vecs[0] = '{x: 8'hB4, s: 3'd2, lr: 1'b0, al: 1'b1, y: 8'hED};
        vecs[1] = '{x: 8'h81, s: 3'd3, lr: 1'b1, al: 1'b0, y: 8'h08};
        vecs[2] = '{x: 8'h81, s: 3'd7, lr: 1'b0, al: 1'b0, y: 8'h01};
        vecs[3] = '{x: 8'h81, s: 3'd7, lr: 1'b0, al: 1'b1, y: 8'hFF};
        vecs[4] = '{x: 8'h7F, s: 3'd1, lr: 1'b0, al: 1'b1, y: 8'h3F};
        vecs[5] = '{x: 8'h5A, s: 3'd0, lr: 1'b1, al: 1'b1, y: 8'h5A};
        vecs[6] = '{x: 8'h01, s: 3'd7, lr: 1'b1, al: 1'b0, y: 8'h80};
        vecs[7] = '{x: 8'hC3, s: 3'd4, lr: 1'b0, al: 1'b0, y: 8'h0C};
        vecs[8] = '{x: 8'h96, s: 3'd3, lr: 1'b1, al: 1'b1, y: 8'hB0};
        vecs[9] = '{x: 8'hF0, s: 3'd4, lr: 1'b0, al: 1'b1, y: 8'hFF};

        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_shamt = '0;
        in_lr = 1'b0; in_al = 1'b0; res_ready = 1'b0; tb_tag = 4'd0; last_tag = 4'd0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_y", 32'(res_y), 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_sh_x", 32'(sh_x), 32'd0);
        check("rst_sh_ctl", 32'({sh_shamt, sh_lr, sh_al}), 32'd0);
        rst_n     = 1'b1;
        res_ready = 1'b1;

        // Latency: push at E0, operands visible in cycle 2, result valid in cycle 5.
        push_cmd(8'hB4, 3'd2, 1'b0, 1'b1);
        tick();
        check("lat_sh_x", 32'(sh_x), 32'hB4);
        check("lat_sh_ctl", 32'({sh_shamt, sh_lr, sh_al}), 32'({3'd2, 1'b0, 1'b1}));
        tick();
        tick();
        check("lat_not_yet", 32'(res_valid), 32'd0);
        tick();
        check("lat_valid", 32'(res_valid), 32'd1);
        check("lat_y", 32'(res_y), 32'hED);
        check("lat_tag", 32'(res_tag), 32'd0);
        tick();

        for (int i = 0; i < 10; i++) begin
            push_cmd(vecs[i].x, vecs[i].s, vecs[i].lr, vecs[i].al);
            wait_valid("vec_valid");
            check($sformatf("vec%0d_y", i), 32'(res_y), 32'(vecs[i].y));
            check($sformatf("vec%0d_tag", i), 32'(res_tag), 32'(last_tag));
            tick();
        end

        // Burst of 6 with the consumer stalled.
        do_reset();
        res_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 6; i++) begin
            bx[i] = 8'((i + 1) * 17); bs[i] = 3'(i + 1); blr[i] = 1'(i % 2); bal[i] = 1'b1;
            push_cmd(bx[i], bs[i], blr[i], bal[i]);
        end
        tick(); tick(); tick();
        check("burst_full", 32'(in_ready), 32'd0);
        check("burst_first_valid", 32'(res_valid), 32'd1);
        check("burst_first_y", 32'(res_y), 32'(shf(bx[0], bs[0], blr[0], bal[0])));
        check("burst_first_tag", 32'(res_tag), 32'd0);
        check("burst_stall_sh_x", 32'(sh_x), 32'(bx[1]));
        for (int i = 0; i < 5; i++) tick();
        check("burst_hold_sh_x", 32'(sh_x), 32'(bx[1]));
        check("burst_hold_sh_y", 32'(sh_y), 32'(shf(bx[1], bs[1], blr[1], bal[1])));
        check("burst_hold_tag", 32'(res_tag), 32'd0);
        res_ready = 1'b1;
        wait_drain("burst_drain");
        check("burst_count", 32'(n_out - n0), 32'd6);

        // Backpressure for 10 cycles with a pending push, then back-to-back release.
        res_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 7; i++) begin
            bx[i] = 8'(8'h40 + i * 9); bs[i] = 3'(7 - i); blr[i] = 1'(i / 2 % 2); bal[i] = 1'(i % 2);
        end
        for (int i = 0; i < 6; i++) push_cmd(bx[i], bs[i], blr[i], bal[i]);
        tick(); tick(); tick();
        check("bp_tag_before", 32'(res_tag), 32'd6);
        in_valid = 1'b1; in_x = bx[6]; in_shamt = bs[6]; in_lr = blr[6]; in_al = bal[6];
        for (int i = 0; i < 10; i++) tick();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(res_valid), 32'd1);
        check("bp_y", 32'(res_y), 32'(shf(bx[0], bs[0], blr[0], bal[0])));
        check("bp_tag", 32'(res_tag), 32'd6);
        check("bp_sh_x", 32'(sh_x), 32'(bx[1]));
        check("bp_sh_y", 32'(sh_y), 32'(shf(bx[1], bs[1], blr[1], bal[1])));
        res_ready = 1'b1;
        fork
            push_cmd(bx[6], bs[6], blr[6], bal[6]);
            begin
                tick();
                check("b2b_valid", 32'(res_valid), 32'd1);
                check("b2b_tag", 32'(res_tag), 32'd7);
                check("b2b_y", 32'(res_y), 32'(shf(bx[1], bs[1], blr[1], bal[1])));
            end
        join
        wait_drain("bp_drain");
        check("bp_count", 32'(n_out - n0), 32'd7);

        // Reset while the first command is in ISSUE2 and two more are queued.
        do_reset();
        push_cmd(8'hA5, 3'd1, 1'b1, 1'b1);
        push_cmd(8'h5C, 3'd2, 1'b0, 1'b0);
        push_cmd(8'hE7, 3'd3, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_sh_x", 32'(sh_x), 32'd0);
        check("mid_rst_sh_ctl", 32'({sh_shamt, sh_lr, sh_al}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_y_tag", 32'({res_y, res_tag}), 32'd0);
        exp_q.delete();
        tb_tag = 4'd0;
        rst_n  = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("mid_rst_nothing_out", 32'(res_valid), 32'd0);
        push_cmd(8'h3C, 3'd1, 1'b1, 1'b0);
        wait_valid("post_rst_valid");
        check("post_rst_y", 32'(res_y), 32'h78);
        check("post_rst_tag", 32'(res_tag), 32'd0);
        tick();

        // 17-command stream: tag wraps 15 -> 0 and FIFO pointers wrap several times.
        do_reset();
        res_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 17; i++) begin
            push_cmd(8'(i * 37 + 5), 3'(i), 1'(i / 2 % 2), 1'(i % 2));
        end
        check("stream_wrap_tag", 32'(last_tag), 32'd0);
        wait_drain("stream_drain");
        check("stream_count", 32'(n_out - n0), 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
